bcd_conv_sched: RTL and testbench

Round-robin scheduler that shares one subtractive binary-to-BCD conversion engine among several 12-bit requesters, such as fuzzy-controller inputs and outputs headed for the 7-segment display path. It arbitrates requests, hands the winning value to the engine with a start pulse, and waits for the engine's done pulse. It then returns the 4-digit BCD result tagged with the channel number, and reports an error if the engine times out.

---
 rtl/bcd_conv_sched.sv | 150 +++++++++++++++
 tb/tb_bcd_conv_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler that shares one binary-to-BCD conversion engine among NCH requesters.
// Each job returns the engine's 4-digit result tagged with its channel, or an error result on engine timeout.
module bcd_conv_sched #(
  parameter int NCH     = 4,
  parameter int W       = 12,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic [NCH*W-1:0] val,
  output logic [NCH-1:0]   gnt,
  output logic             conv_start,
  output logic [W-1:0]     conv_value,
  input  logic             conv_done,
  input  logic [15:0]      conv_bcd,
  output logic             res_valid,
  output logic [2:0]       res_ch,
  output logic [15:0]      res_bcd,
  output logic             res_err,
  output logic             busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state, state_nxt;
  logic [2:0]     ptr, ptr_nxt;
  logic [2:0]     cur_ch, cur_ch_nxt;
  logic [TW-1:0]  tcnt, tcnt_nxt;
  logic [NCH-1:0] gnt_nxt;
  logic           conv_start_nxt;
  logic [W-1:0]   conv_value_nxt;
  logic           res_valid_nxt;
  logic [2:0]     res_ch_nxt;
  logic [15:0]    res_bcd_nxt;
  logic           res_err_nxt;

  logic [2:0]     pick_lo, pick_hi, pick;
  logic           found_hi;
  logic [W-1:0]   pick_val;

  // Round robin: first request at or above ptr, otherwise the lowest request overall.
  always_comb begin : arbitrate
    pick_lo  = '0;
    pick_hi  = '0;
    found_hi = 1'b0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (req[j]) begin
        pick_lo = 3'(j);
        if (3'(j) >= ptr) begin
          pick_hi  = 3'(j);
          found_hi = 1'b1;
        end
      end
    end
    pick     = found_hi ? pick_hi : pick_lo;
    pick_val = '0;
    for (int j = 0; j < NCH; j++) begin
      if (3'(j) == pick) pick_val = val[j*W +: W];
    end
  end

  // NOTE: combinational next-state logic uses blocking '=' with every output
  // defaulted first, so no path through the block can infer a latch.
  always_comb begin : next_state
    state_nxt      = state;
    ptr_nxt        = ptr;
    cur_ch_nxt     = cur_ch;
    tcnt_nxt       = tcnt;
    gnt_nxt        = '0;
    conv_start_nxt = 1'b0;
    conv_value_nxt = conv_value;
    res_valid_nxt  = 1'b0;
    res_ch_nxt     = res_ch;
    res_bcd_nxt    = res_bcd;
    res_err_nxt    = res_err;

    unique case (state)
      IDLE: begin
        if (|req) begin
          for (int j = 0; j < NCH; j++) gnt_nxt[j] = (3'(j) == pick);
          conv_start_nxt = 1'b1;
          conv_value_nxt = pick_val;
          cur_ch_nxt     = pick;
          ptr_nxt        = (pick == 3'(NCH - 1)) ? 3'd0 : pick + 3'd1;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        tcnt_nxt  = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // tcnt is still 0 on the first WAIT edge, so the error pulse lands
        // TIMEOUT+2 cycles after the grant; a done on that same edge wins.
        if (conv_done) begin
          res_valid_nxt = 1'b1;
          res_ch_nxt    = cur_ch;
          res_bcd_nxt   = conv_bcd;
          res_err_nxt   = 1'b0;
          state_nxt     = IDLE;
        end else if (tcnt == TW'(TIMEOUT)) begin
          res_valid_nxt = 1'b1;
          res_ch_nxt    = cur_ch;
          res_bcd_nxt   = 16'h0000;
          res_err_nxt   = 1'b1;
          state_nxt     = IDLE;
        end else begin
          tcnt_nxt = tcnt + TW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: reset is synchronous and active-high; every register, outputs
  // included, is cleared so an aborted job leaves no stale result behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cur_ch     <= '0;
      tcnt       <= '0;
      gnt        <= '0;
      conv_start <= 1'b0;
      conv_value <= '0;
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_bcd    <= '0;
      res_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      cur_ch     <= cur_ch_nxt;
      tcnt       <= tcnt_nxt;
      gnt        <= gnt_nxt;
      conv_start <= conv_start_nxt;
      conv_value <= conv_value_nxt;
      res_valid  <= res_valid_nxt;
      res_ch     <= res_ch_nxt;
      res_bcd    <= res_bcd_nxt;
      res_err    <= res_err_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Self-checking bench for bcd_conv_sched: table-driven single jobs plus directed
// sequences for arbitration order, fairness, timeout, done/timeout race and reset abort.
module tb_bcd_conv_sched;

  localparam int NCH = 4;
  localparam int W   = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   req;
  logic [NCH*W-1:0] val;
  logic [NCH-1:0]   gnt;
  logic             conv_start;
  logic [W-1:0]     conv_value;
  logic             conv_done;
  logic [15:0]      conv_bcd;
  logic             res_valid;
  logic [2:0]       res_ch;
  logic [15:0]      res_bcd;
  logic             res_err;
  logic             busy;

  bcd_conv_sched #(.NCH(NCH), .W(W), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .val(val), .gnt(gnt),
    .conv_start(conv_start), .conv_value(conv_value),
    .conv_done(conv_done), .conv_bcd(conv_bcd),
    .res_valid(res_valid), .res_ch(res_ch), .res_bcd(res_bcd),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Engine model: answers eng_lat cycles after conv_start; manual pulses OR in.
  bit          eng_on  = 1'b1;
  int          eng_lat = 10;
  int          eng_cnt = 0;
  logic        eng_done = 1'b0;
  logic [15:0] eng_bcd  = '0;
  logic        man_done;
  logic [15:0] man_bcd;

  function automatic logic [15:0] bin2bcd(input logic [W-1:0] b);
    int v;
    v = int'(b);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(negedge clk) begin
    eng_done = 1'b0;
    if (rst) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) eng_done = 1'b1;
      end
      if (conv_start && eng_on) begin
        eng_cnt = eng_lat;
        eng_bcd = bin2bcd(conv_value);
      end
    end
  end

  assign conv_done = eng_done | man_done;
  assign conv_bcd  = man_done ? man_bcd : eng_bcd;

  task automatic wait_gnt(output bit ok, output logic [NCH-1:0] g, output logic [W-1:0] cv,
                          output logic st, output logic bz, output int c);
    ok = 1'b0; g = '0; cv = '0; st = 1'b0; bz = 1'b0; c = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (|gnt) begin
        ok = 1'b1; g = gnt; cv = conv_value; st = conv_start; bz = busy; c = cyc;
      end
    end
  endtask

  task automatic wait_res(output bit ok, output logic [2:0] ch, output logic [15:0] bcd,
                          output logic err, output int c);
    ok = 1'b0; ch = '0; bcd = '0; err = 1'b0; c = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1; ch = res_ch; bcd = res_bcd; err = res_err; c = cyc;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          ch;
    logic [11:0] value;
    logic [15:0] bcd;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit             ok;
    logic [NCH-1:0] g;
    logic [W-1:0]   cv;
    logic           st, bz, err;
    logic [2:0]     rch;
    logic [15:0]    rbcd;
    int             c0, c1, seen;
    logic [NCH-1:0] eg;
    int             order[4];
    logic [11:0]    sim_val[4];
    logic [15:0]    sim_bcd[4];

    tbl[0] = '{2, 12'd1234, 16'h1234};
    tbl[1] = '{0, 12'd0,    16'h0000};
    tbl[2] = '{1, 12'd9,    16'h0009};
    tbl[3] = '{3, 12'd4095, 16'h4095};
    tbl[4] = '{2, 12'd999,  16'h0999};
    tbl[5] = '{1, 12'd58,   16'h0058};

    rst = 1'b1; req = '0; val = '0; man_done = 1'b0; man_bcd = '0;
    repeat (3) @(negedge clk);
    check("reset gnt",        32'(gnt),        32'h0);
    check("reset conv_start", 32'(conv_start), 32'h0);
    check("reset conv_value", 32'(conv_value), 32'h0);
    check("reset res_valid",  32'(res_valid),  32'h0);
    check("reset res_bcd",    32'(res_bcd),    32'h0);
    check("reset busy",       32'(busy),       32'h0);
    rst = 1'b0;

    // Single jobs from the table
    foreach (tbl[k]) begin
      val[tbl[k].ch*W +: W] = tbl[k].value;
      req[tbl[k].ch] = 1'b1;
      wait_gnt(ok, g, cv, st, bz, c0);
      req = '0;
      eg = '0; eg[tbl[k].ch] = 1'b1;
      check($sformatf("tbl%0d grant seen", k), 32'(ok), 32'h1);
      check($sformatf("tbl%0d gnt", k),        32'(g),  32'(eg));
      check($sformatf("tbl%0d conv_value", k), 32'(cv), 32'(tbl[k].value));
      check($sformatf("tbl%0d start+busy", k), 32'({st, bz}), 32'h3);
      @(negedge clk);
      check($sformatf("tbl%0d gnt one-shot", k), 32'({gnt, conv_start, busy}), 32'h1);
      wait_res(ok, rch, rbcd, err, c1);
      check($sformatf("tbl%0d result seen", k), 32'(ok),   32'h1);
      check($sformatf("tbl%0d res_ch", k),      32'(rch),  32'(tbl[k].ch));
      check($sformatf("tbl%0d res_bcd", k),     32'(rbcd), 32'(tbl[k].bcd));
      check($sformatf("tbl%0d res_err", k),     32'(err),  32'h0);
      // done sampled 11 edges after grant edge, result pulse one cycle later
      check($sformatf("tbl%0d latency", k),     32'(c1 - c0), 32'd11);
    end

    // Simultaneous requests after reset: ch0..3 in order
    do_reset();
    sim_val = '{12'd0, 12'd9, 12'd999, 12'd4095};
    sim_bcd = '{16'h0000, 16'h0009, 16'h0999, 16'h4095};
    for (int k = 0; k < 4; k++) val[k*W +: W] = sim_val[k];
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(ok, g, cv, st, bz, c0);
      req = req & ~g;
      eg = '0; eg[k] = 1'b1;
      check($sformatf("sim%0d gnt", k), 32'(g), 32'(eg));
      wait_res(ok, rch, rbcd, err, c1);
      check($sformatf("sim%0d res", k), 32'({rch, rbcd, err}), 32'({3'(k), sim_bcd[k], 1'b0}));
    end

    // Fairness: req[0] held, req[3] raised once
    do_reset();
    eng_lat = 3;
    req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(ok, g, cv, st, bz, c0);
      order[k] = ok ? $clog2(int'(g)) : -1;
      req[3] = req[3] & ~g[3];
    end
    check("fair grant 0", 32'(order[0]), 32'd0);
    check("fair grant 1", 32'(order[1]), 32'd3);
    check("fair grant 2", 32'(order[2]), 32'd0);
    check("fair grant 3", 32'(order[3]), 32'd0);
    req = '0;
    wait_res(ok, rch, rbcd, err, c1);
    repeat (2) @(negedge clk);

    // Timeout: engine silent
    eng_on = 1'b0;
    val[1*W +: W] = 12'd777;
    req = 4'b0010;
    wait_gnt(ok, g, cv, st, bz, c0);
    req = '0;
    wait_res(ok, rch, rbcd, err, c1);
    check("timeout seen",    32'(ok),      32'h1);
    check("timeout spacing", 32'(c1 - c0), 32'd66);
    check("timeout result",  32'({rch, rbcd, err}), 32'({3'd1, 16'h0000, 1'b1}));
    @(negedge clk);
    check("timeout idle", 32'({busy, res_valid}), 32'h0);
    eng_on = 1'b1; eng_lat = 5;
    val[2*W +: W] = 12'd321;
    req = 4'b0100;
    wait_gnt(ok, g, cv, st, bz, c0);
    req = '0;
    check("post-timeout gnt", 32'(g), 32'h4);
    wait_res(ok, rch, rbcd, err, c1);
    check("post-timeout res", 32'({rch, rbcd, err}), 32'({3'd2, 16'h0321, 1'b0}));

    // Done on the timeout edge wins
    eng_on = 1'b0;
    val[3*W +: W] = 12'd5;
    req = 4'b1000;
    wait_gnt(ok, g, cv, st, bz, c0);
    req = '0;
    repeat (65) @(negedge clk);
    man_done = 1'b1; man_bcd = 16'h0777;
    @(negedge clk);
    man_done = 1'b0;
    check("race res_valid", 32'(res_valid), 32'h1);
    check("race result",    32'({res_ch, res_bcd, res_err}), 32'({3'd3, 16'h0777, 1'b0}));

    // Spurious done in IDLE
    repeat (2) @(negedge clk);
    man_done = 1'b1; man_bcd = 16'h5555;
    @(negedge clk);
    man_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid || busy || (|gnt)) seen++;
    end
    check("spurious done ignored", 32'(seen), 32'd0);
    check("spurious bcd held",     32'(res_bcd), 32'h0777);

    // Reset three cycles into WAIT
    val[2*W +: W] = 12'd42;
    req = 4'b0100;
    wait_gnt(ok, g, cv, st, bz, c0);
    req = '0;
    check("abort gnt", 32'(g), 32'h4);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort outputs",
          32'({gnt, conv_start, res_valid, res_ch, res_err, busy}), 32'h0);
    check("abort values", {conv_value, res_bcd}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    man_done = 1'b1; man_bcd = 16'h1111;
    @(negedge clk);
    man_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid || busy) seen++;
    end
    check("late done ignored", 32'(seen), 32'd0);
    eng_on = 1'b1;
    val[0*W +: W] = 12'd100;
    val[3*W +: W] = 12'd300;
    req = 4'b1001;
    wait_gnt(ok, g, cv, st, bz, c0);
    req = '0;
    check("post-reset priority", 32'(g), 32'h1);
    wait_res(ok, rch, rbcd, err, c1);
    check("post-reset res", 32'({rch, rbcd, err}), 32'({3'd0, 16'h0100, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
